// File: rtl/clic_dispatch.sv
// clic_dispatch: vectored, nested interrupt dispatcher.
// Holds per-vector pending/enable/priority CSRs, arbitrates the highest
// eligible vector above max(running level, threshold), offers it to the core
// and tracks preemption nesting on a hardware priority stack.
// Optional feature macro: CLIC_TIMESTAMP_EN (free-running counter captured
// into a per-vector timestamp whenever that vector becomes pending).
//
// Handshake: irq_valid/irq_id are registered. While irq_valid is high the
// offered id is locked; the transfer happens on a cycle where irq_valid and
// irq_ready are both high and the vector is still eligible. If the locked
// vector stops being eligible, irq_valid drops without a transfer.
// irq_valid is high exactly when the FSM is in S_OFFER, so it doubles as the
// observable FSM state.
module clic_dispatch #(
  parameter int VecSize        = 8,
  parameter int PrioNum        = 4,
  parameter int StackDepth     = 4,
  parameter int TimeStampWidth = 8,
  localparam int VecWidth      = $clog2(VecSize),
  localparam int PrioWidth     = $clog2(PrioNum),
  localparam int DepthWidth    = $clog2(StackDepth + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [VecSize-1:0]    ext_irq,
  input  logic                  csr_we,
  input  logic [11:0]           csr_addr,
  input  logic [31:0]           csr_wdata,
  output logic [31:0]           csr_rdata,
  output logic                  irq_valid,
  output logic [VecWidth-1:0]   irq_id,
  input  logic                  irq_ready,
  input  logic                  irq_return,
  output logic [PrioWidth-1:0]  cur_prio,
  output logic [DepthWidth-1:0] stack_depth
);

  typedef enum logic {S_IDLE, S_OFFER} state_e;

  state_e                state_q, state_d;
  logic [VecSize-1:0]    pend_q, pend_d, en_q, en_d, ext_q;
  logic [PrioWidth-1:0]  prio_q [VecSize];
  logic [PrioWidth-1:0]  prio_d [VecSize];
  logic [PrioWidth-1:0]  stack_q [StackDepth];
  logic [PrioWidth-1:0]  stack_d [StackDepth];
  logic [PrioWidth-1:0]  thresh_q, thresh_d, cur_prio_q, cur_prio_d;
  logic [DepthWidth-1:0] depth_q, depth_d;
  logic [VecWidth-1:0]   id_q, id_d;

  logic [PrioWidth-1:0]  thr_eff, win_prio, popped, prio_mid;
  logic [DepthWidth-1:0] depth_mid;
  logic [VecSize-1:0]    elig;
  logic [VecWidth-1:0]   win_id;
  logic                  win_found, full, accept, ret_fire;

  // Eligibility of every vector and fixed-priority arbitration (ties -> lowest index)
  always_comb begin
    thr_eff   = (cur_prio_q > thresh_q) ? cur_prio_q : thresh_q;
    full      = (depth_q == DepthWidth'(StackDepth));
    elig      = '0;
    win_found = 1'b0;
    win_id    = '0;
    win_prio  = '0;
    for (int i = 0; i < VecSize; i++) begin
      elig[i] = pend_q[i] & en_q[i] & (prio_q[i] > thr_eff) & ~full;
      if (elig[i] && (!win_found || prio_q[i] > win_prio)) begin
        win_found = 1'b1;
        win_id    = VecWidth'(i);
        win_prio  = prio_q[i];
      end
    end
  end

  // Offer FSM: lock a winner, then resolve by accept or loss of eligibility
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_OFFER;
          id_d    = win_id;
        end
      end
      S_OFFER: begin
        if (!elig[id_q]) begin
          state_d = S_IDLE;
        end else if (irq_ready) begin
          accept  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Priority stack: a return pops first, then an accept pushes onto the result
  always_comb begin
    ret_fire = irq_return && (depth_q != '0);
    popped   = '0;
    for (int k = 0; k < StackDepth; k++) begin
      if (DepthWidth'(k) == depth_q - DepthWidth'(1)) popped = stack_q[k];
    end
    depth_mid  = ret_fire ? depth_q - DepthWidth'(1) : depth_q;
    prio_mid   = ret_fire ? popped : cur_prio_q;
    depth_d    = depth_mid;
    cur_prio_d = prio_mid;
    for (int k = 0; k < StackDepth; k++) begin
      stack_d[k] = stack_q[k];
      if (accept && DepthWidth'(k) == depth_mid) stack_d[k] = prio_mid;
    end
    if (accept) begin
      depth_d    = depth_mid + DepthWidth'(1);
      cur_prio_d = prio_q[id_q];
    end
  end

  // CSR writes, accept clearing pending, and edge-set pending (edge wins last)
  always_comb begin
    thresh_d = thresh_q;
    if (csr_we && csr_addr == 12'h347) thresh_d = csr_wdata[PrioWidth-1:0];
    for (int i = 0; i < VecSize; i++) begin
      pend_d[i] = pend_q[i];
      en_d[i]   = en_q[i];
      prio_d[i] = prio_q[i];
      if (csr_we && csr_addr == 12'hb00 + 12'(i)) begin
        pend_d[i] = csr_wdata[0];
        en_d[i]   = csr_wdata[1];
        prio_d[i] = csr_wdata[PrioWidth+1:2];
      end
      if (accept && id_q == VecWidth'(i)) pend_d[i] = 1'b0;
      if (ext_irq[i] && !ext_q[i])        pend_d[i] = 1'b1;
    end
  end

`ifdef CLIC_TIMESTAMP_EN
  logic [TimeStampWidth-1:0] ts_cnt_q;
  logic [TimeStampWidth-1:0] ts_q [VecSize];

  // Free-running stamp counter, captured when a vector goes not-pending -> pending
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_cnt_q <= '0;
      for (int i = 0; i < VecSize; i++) ts_q[i] <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + TimeStampWidth'(1);
      for (int i = 0; i < VecSize; i++) begin
        if (!pend_q[i] && pend_d[i]) ts_q[i] <= ts_cnt_q;
      end
    end
  end
`else
  logic [TimeStampWidth-1:0] unused_ts;
  assign unused_ts = '0;
`endif

  // CSR read mux, purely from current state
  always_comb begin
    csr_rdata = '0;
    for (int i = 0; i < VecSize; i++) begin
      if (csr_addr == 12'hb00 + 12'(i)) csr_rdata = 32'({prio_q[i], en_q[i], pend_q[i]});
`ifdef CLIC_TIMESTAMP_EN
      if (csr_addr == 12'hb40 + 12'(i)) csr_rdata = 32'(ts_q[i]);
`endif
    end
    if (csr_addr == 12'h347) csr_rdata = 32'(thresh_q);
    if (csr_addr == 12'h350) csr_rdata = 32'(depth_q);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      id_q       <= '0;
      pend_q     <= '0;
      en_q       <= '0;
      ext_q      <= '0;
      thresh_q   <= '0;
      cur_prio_q <= '0;
      depth_q    <= '0;
      for (int i = 0; i < VecSize; i++)    prio_q[i]  <= '0;
      for (int k = 0; k < StackDepth; k++) stack_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      pend_q     <= pend_d;
      en_q       <= en_d;
      ext_q      <= ext_irq;
      thresh_q   <= thresh_d;
      cur_prio_q <= cur_prio_d;
      depth_q    <= depth_d;
      for (int i = 0; i < VecSize; i++)    prio_q[i]  <= prio_d[i];
      for (int k = 0; k < StackDepth; k++) stack_q[k] <= stack_d[k];
    end
  end

  logic unused_wdata;
  assign unused_wdata = ^csr_wdata[31:PrioWidth+2];

  assign irq_valid   = (state_q == S_OFFER);
  assign irq_id      = id_q;
  assign cur_prio    = cur_prio_q;
  assign stack_depth = depth_q;

endmodule

// File: tb/tb_clic_dispatch.sv
// Bench for clic_dispatch: arbitration vector table, directed multi-cycle
// sequences, and a randomized run against a behavioural model.
// A second instance with StackDepth=2 shares all inputs to exercise the
// full-stack hold-off.
module tb_clic_dispatch;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  ext_irq;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        irq_ready, irq_return;

  logic [31:0] csr_rdata, d2_rdata;
  logic        irq_valid, d2_valid;
  logic [2:0]  irq_id, d2_id;
  logic [1:0]  cur_prio, d2_prio;
  logic [2:0]  stack_depth;
  logic [1:0]  d2_depth;

  clic_dispatch dut (
    .clk(clk), .reset(reset), .ext_irq(ext_irq), .csr_we(csr_we),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .irq_valid(irq_valid), .irq_id(irq_id), .irq_ready(irq_ready),
    .irq_return(irq_return), .cur_prio(cur_prio), .stack_depth(stack_depth)
  );

  clic_dispatch #(.StackDepth(2)) dut2 (
    .clk(clk), .reset(reset), .ext_irq(ext_irq), .csr_we(csr_we),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(d2_rdata),
    .irq_valid(d2_valid), .irq_id(d2_id), .irq_ready(irq_ready),
    .irq_return(irq_return), .cur_prio(d2_prio), .stack_depth(d2_depth)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ext_irq = '0; csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;
    irq_ready = 1'b0; irq_return = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    csr_we = 1'b1; csr_addr = addr; csr_wdata = data;
    tick();
    csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;
  endtask

  task automatic vec_wr(input int i, input logic en, input logic [1:0] pr, input logic pend);
    csr_write(12'hb00 + 12'(i), {28'd0, pr, en, pend});
  endtask

  task automatic check_rd(input string name, input logic [11:0] addr, input logic [31:0] exp);
    csr_addr = addr;
    #1;
    check(name, csr_rdata, exp);
  endtask

  task automatic accept_one();
    irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
  endtask

  task automatic do_return();
    irq_return = 1'b1;
    tick();
    irq_return = 1'b0;
  endtask

  // behavioural reference model
  bit m_pend[8], m_en[8], m_ext[8];
  int m_pr[8];
  int m_thr, m_cur, m_id;
  bit m_off;
  int m_stk[$];

  function automatic void m_reset();
    for (int i = 0; i < 8; i++) begin
      m_pend[i] = 0; m_en[i] = 0; m_ext[i] = 0; m_pr[i] = 0;
    end
    m_thr = 0; m_cur = 0; m_id = 0; m_off = 0;
    m_stk.delete();
  endfunction

  function automatic bit m_elig(input int i);
    int lvl;
    lvl = (m_cur > m_thr) ? m_cur : m_thr;
    return m_pend[i] && m_en[i] && (m_pr[i] > lvl) && (m_stk.size() < 4);
  endfunction

  function automatic logic [31:0] m_rd(input logic [11:0] addr);
    for (int i = 0; i < 8; i++)
      if (addr == 12'hb00 + 12'(i)) return m_pr[i] * 4 + m_en[i] * 2 + m_pend[i];
    if (addr == 12'h347) return m_thr;
    if (addr == 12'h350) return m_stk.size();
    return 0;
  endfunction

  function automatic void m_step();
    int  best, acc_id;
    bit  acc, drop;
    best = -1;
    for (int p = 3; p >= 1; p--)
      for (int i = 0; i < 8; i++)
        if (best < 0 && m_pr[i] == p && m_elig(i)) best = i;
    acc    = m_off && irq_ready && m_elig(m_id);
    drop   = m_off && !m_elig(m_id);
    acc_id = m_id;
    if (irq_return && m_stk.size() > 0) m_cur = m_stk.pop_back();
    if (acc) begin
      m_stk.push_back(m_cur);
      m_cur = m_pr[acc_id];
    end
    if (!m_off && best >= 0) begin
      m_off = 1; m_id = best;
    end else if (acc || drop) begin
      m_off = 0;
    end
    if (csr_we) begin
      for (int i = 0; i < 8; i++)
        if (csr_addr == 12'hb00 + 12'(i)) begin
          m_pend[i] = csr_wdata[0];
          m_en[i]   = csr_wdata[1];
          m_pr[i]   = int'(csr_wdata[3:2]);
        end
      if (csr_addr == 12'h347) m_thr = int'(csr_wdata[1:0]);
    end
    if (acc) m_pend[acc_id] = 0;
    for (int i = 0; i < 8; i++) begin
      if (ext_irq[i] && !m_ext[i]) m_pend[i] = 1;
      m_ext[i] = ext_irq[i];
    end
  endfunction

  // arbitration vector table
  typedef struct {
    logic [7:0]  pend;
    logic [7:0]  en;
    logic [15:0] prio;
    logic [1:0]  thr;
    logic        exp_valid;
    logic [2:0]  exp_id;
  } arb_t;

  arb_t tbl[9];

  initial begin
    logic [31:0] a_ts;
    logic [11:0] ra;
    int          r;

    tbl[0] = '{8'h08, 8'h08, 16'h0080, 2'd0, 1'b1, 3'd3};
    tbl[1] = '{8'h22, 8'h22, 16'h0C0C, 2'd0, 1'b1, 3'd1};
    tbl[2] = '{8'hFF, 8'hFF, 16'hD555, 2'd0, 1'b1, 3'd7};
    tbl[3] = '{8'h10, 8'h00, 16'h0300, 2'd0, 1'b0, 3'd0};
    tbl[4] = '{8'h01, 8'h01, 16'h0000, 2'd0, 1'b0, 3'd0};
    tbl[5] = '{8'h01, 8'h01, 16'h0002, 2'd2, 1'b0, 3'd0};
    tbl[6] = '{8'h11, 8'h11, 16'h0302, 2'd2, 1'b1, 3'd4};
    tbl[7] = '{8'h54, 8'h54, 16'h2120, 2'd0, 1'b1, 3'd2};
    tbl[8] = '{8'h81, 8'h81, 16'h8001, 2'd0, 1'b1, 3'd7};

    // reset state
    do_reset();
    check("rst_valid", irq_valid, 0);
    check("rst_id", irq_id, 0);
    check("rst_cur", cur_prio, 0);
    check("rst_depth", stack_depth, 0);
    check_rd("rst_vec3", 12'hb03, 0);
    check_rd("rst_thr", 12'h347, 0);
    check_rd("rst_unmapped", 12'h123, 0);

    // table: configure, raise all pending lines together, check offer timing
    for (int t = 0; t < 9; t++) begin
      do_reset();
      csr_write(12'h347, {30'd0, tbl[t].thr});
      for (int i = 0; i < 8; i++) vec_wr(i, tbl[t].en[i], tbl[t].prio[2*i +: 2], 1'b0);
      ext_irq = tbl[t].pend;
      tick();
      ext_irq = '0;
      check($sformatf("arb%0d_early", t), irq_valid, 0);
      tick();
      check($sformatf("arb%0d_valid", t), irq_valid, tbl[t].exp_valid);
      check($sformatf("arb%0d_id", t), irq_id, tbl[t].exp_id);
    end

    // single vector offer and accept
    do_reset();
    vec_wr(3, 1'b1, 2'd2, 1'b0);
    ext_irq = 8'h08; tick(); ext_irq = '0;
    check("a_n1_valid", irq_valid, 0);
    tick();
    check("a_valid", irq_valid, 1);
    check("a_id", irq_id, 3);
    accept_one();
    check("a_valid_low", irq_valid, 0);
    check("a_cur", cur_prio, 2);
    check("a_depth", stack_depth, 1);
    check_rd("a_vec3", 12'hb03, 32'hA);

    // equal-priority tie, then no self-preemption until return
    do_reset();
    vec_wr(1, 1'b1, 2'd3, 1'b0);
    vec_wr(5, 1'b1, 2'd3, 1'b0);
    ext_irq = 8'h22; tick(); ext_irq = '0; tick();
    check("b_id", irq_id, 1);
    accept_one();
    check("b_cur", cur_prio, 3);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("b_hold", irq_valid, 0);
    end
    check_rd("b_vec5", 12'hb05, 32'hF);
    do_return();
    check("b_ret_cur", cur_prio, 0);
    check("b_ret_depth", stack_depth, 0);
    tick();
    check("b_valid5", irq_valid, 1);
    check("b_id5", irq_id, 5);

    // preemption, nested returns, extra return ignored
    do_reset();
    vec_wr(3, 1'b1, 2'd1, 1'b0);
    vec_wr(6, 1'b1, 2'd3, 1'b0);
    ext_irq = 8'h08; tick(); ext_irq = '0; tick();
    check("c_id3", irq_id, 3);
    accept_one();
    ext_irq = 8'h40; tick(); ext_irq = '0; tick();
    check("c_valid6", irq_valid, 1);
    check("c_id6", irq_id, 6);
    accept_one();
    check("c_cur3", cur_prio, 3);
    check("c_depth2", stack_depth, 2);
    irq_return = 1'b1;
    tick();
    check("c_ret1_cur", cur_prio, 1);
    check("c_ret1_depth", stack_depth, 1);
    tick();
    check("c_ret2_cur", cur_prio, 0);
    check("c_ret2_depth", stack_depth, 0);
    tick();
    check("c_ret3_cur", cur_prio, 0);
    check("c_ret3_depth", stack_depth, 0);
    irq_return = 1'b0;

    // threshold gating and drop of a locked offer
    do_reset();
    csr_write(12'h347, 32'd2);
    vec_wr(0, 1'b1, 2'd2, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("d_blocked", irq_valid, 0);
    end
    csr_write(12'h347, 32'd1);
    check("d_wr_edge", irq_valid, 0);
    tick();
    check("d_offer", irq_valid, 1);
    check("d_id", irq_id, 0);
    csr_write(12'h347, 32'd3);
    tick();
    check("d_drop", irq_valid, 0);
    check_rd("d_pend_kept", 12'hb00, 32'hB);

    // full stack on the StackDepth=2 instance
    do_reset();
    vec_wr(1, 1'b1, 2'd1, 1'b1); tick(); accept_one();
    vec_wr(2, 1'b1, 2'd2, 1'b1); tick(); accept_one();
    check("e_d2_depth2", d2_depth, 2);
    vec_wr(3, 1'b1, 2'd3, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("e_d2_held", d2_valid, 0);
    end
    check("e_dut_offer", irq_valid, 1);
    check("e_dut_id", irq_id, 3);
    do_return();
    check("e_d2_depth1", d2_depth, 1);
    check("e_d2_cur1", d2_prio, 1);
    tick();
    check("e_d2_valid", d2_valid, 1);
    check("e_d2_id", d2_id, 3);

    // return and accept in the same cycle
    do_reset();
    vec_wr(1, 1'b1, 2'd1, 1'b1); tick(); accept_one();
    vec_wr(2, 1'b1, 2'd2, 1'b1); tick();
    check("f_id2", irq_id, 2);
    irq_ready = 1'b1; irq_return = 1'b1;
    tick();
    irq_ready = 1'b0; irq_return = 1'b0;
    check("f_depth", stack_depth, 1);
    check("f_cur", cur_prio, 2);
    do_return();
    check("f_ret_cur", cur_prio, 0);
    check("f_ret_depth", stack_depth, 0);

    // accept racing a new edge; accept racing a CSR write
    do_reset();
    vec_wr(3, 1'b1, 2'd2, 1'b0);
    ext_irq = 8'h08; tick(); ext_irq = '0; tick();
    ext_irq = 8'h08; irq_ready = 1'b1;
    tick();
    ext_irq = '0; irq_ready = 1'b0;
    check("g_cur", cur_prio, 2);
    check_rd("g_pend_kept", 12'hb03, 32'hB);
    vec_wr(5, 1'b1, 2'd3, 1'b1); tick();
    check("g_id5", irq_id, 5);
    csr_we = 1'b1; csr_addr = 12'hb05; csr_wdata = 32'h7; irq_ready = 1'b1;
    tick();
    csr_we = 1'b0; irq_ready = 1'b0;
    check("g_depth2", stack_depth, 2);
    check("g_cur3", cur_prio, 3);
    check_rd("g_vec5", 12'hb05, 32'h6);

    // reset while nested
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("h_depth", stack_depth, 0);
    check("h_cur", cur_prio, 0);
    check("h_valid", irq_valid, 0);
    check_rd("h_vec3", 12'hb03, 0);
    tick();
    check("h_no_offer", irq_valid, 0);

    // timestamp capture
    do_reset();
`ifdef CLIC_TIMESTAMP_EN
    repeat (23) tick();
    vec_wr(2, 1'b1, 2'd0, 1'b1);
    check_rd("ts_first", 12'hb42, 32'h17);
    vec_wr(2, 1'b1, 2'd0, 1'b0);
    repeat (250) tick();
    vec_wr(2, 1'b1, 2'd0, 1'b1);
    check_rd("ts_wrap", 12'hb42, 32'h13);
`else
    vec_wr(2, 1'b1, 2'd0, 1'b1);
    check_rd("ts_absent", 12'hb42, 0);
`endif
    a_ts = '0;

    // randomized run against the model
    do_reset();
    m_reset();
    for (int c = 0; c < 600; c++) begin
      check("r_valid", irq_valid, m_off);
      check("r_id", irq_id, m_id);
      check("r_cur", cur_prio, m_cur);
      check("r_depth", stack_depth, m_stk.size());
      csr_we = 1'b0;
      r = $urandom_range(0, 10);
      ra = (r < 8) ? 12'hb00 + 12'(r) : (r == 8) ? 12'h347 : (r == 9) ? 12'h350 : 12'h123;
      check_rd("r_rdata", ra, m_rd(ra));
      ext_irq    = 8'($urandom & $urandom & $urandom);
      irq_ready  = 1'($urandom_range(0, 1));
      irq_return = ($urandom_range(0, 9) == 0);
      csr_we     = ($urandom_range(0, 5) == 0);
      r = $urandom_range(0, 9);
      csr_addr   = (r < 8) ? 12'hb00 + 12'(r) : (r == 8) ? 12'h347 : 12'h350;
      csr_wdata  = $urandom;
      csr_wdata[1] = ($urandom_range(0, 3) != 0);
      m_step();
      tick();
    end
    csr_we = 1'b0; irq_ready = 1'b0; irq_return = 1'b0; ext_irq = '0;

    // report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clic_dispatch.md
# clic_dispatch

Vectored, nested interrupt dispatcher (N-CLIC core) sitting between peripheral interrupt lines and the pipeline. Holds per-vector pending/enable/priority state in CSR space, arbitrates the highest eligible vector above the running level and machine threshold, offers it to the core through a valid/ready handshake, and tracks preemption nesting on a hardware priority stack popped by interrupt return.

## Interface
- VecSize, 8: number of interrupt vectors; VecWidth = $clog2(VecSize)
- PrioNum, 4: priority levels; PrioWidth = $clog2(PrioNum); level 0 never fires
- StackDepth, 4: maximum nesting depth
- TimeStampWidth, 8: timestamp width (only with CLIC_TIMESTAMP_EN)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- ext_irq  in  VecSize  peripheral interrupt lines, rising-edge sensitive
- csr_we  in  1  CSR write strobe
- csr_addr  in  12  CSR address
- csr_wdata  in  32  CSR write data
- csr_rdata  out  32  CSR read data, combinational from current state, 0 for unmapped addresses
- irq_valid  out  1  interrupt offered to core
- irq_id  out  VecWidth  offered vector
- irq_ready  in  1  core takes the offered interrupt
- irq_return  in  1  core executes interrupt return
- cur_prio  out  PrioWidth  running priority level
- stack_depth  out  $clog2(StackDepth+1)  current nesting depth

## Operation
- Vector CSR at 0xb00+i: bit0 pending, bit1 enable, bits[PrioWidth+1:2] prio; other bits read 0, ignored on write.
- Threshold CSR at 0x347: bits[PrioWidth-1:0]. Depth CSR at 0x350: read-only stack_depth.
- ext_irq edge detect: one-register delayed copy; rising edge sets pending[i] next cycle.
- Eligible(i) = pending & enable & prio > max(cur_prio, thresh) & stack not full.
- Arbitration: highest prio eligible; tie -> lowest index.
- FSM IDLE: if any eligible, register winner into irq_id, irq_valid=1, go OFFER.
- FSM OFFER: irq_id locked. irq_valid & irq_ready -> clear pending[id], push cur_prio, cur_prio := prio[id], depth+1, go IDLE with irq_valid=0. If locked vector loses eligibility (cleared, disabled, prio lowered, thresh raised) -> irq_valid=0, go IDLE. Higher-priority arrival does not replace the locked id; it is offered after the current offer resolves.
- irq_return: pop stack into cur_prio, depth-1. Depth 0: ignored, cur_prio stays 0.
- Simultaneous events:
  - irq_return and accept in same cycle: return first, then push; net depth unchanged, cur_prio := prio[id].
  - Accept and csr write to same vector: accept clears pending, other written fields apply.
  - Pending clear (accept or CSR) and ext_irq rising edge same cycle: pending ends set.
  - CSR write to pending and edge set: OR.
- Stack full (depth == StackDepth): no vector eligible; returns still processed.

## Timing
- Reset: all pending/enable/prio 0, thresh 0, cur_prio 0, depth 0, stack entries 0, irq_valid 0, irq_id 0, edge registers 0, FSM IDLE.
- ext_irq rise at cycle n -> pending set at n+1 -> irq_valid at n+2 (if eligible, FSM idle).
- CSR write visible on csr_rdata the cycle after csr_we.
- Accept at cycle n -> cur_prio/depth updated, irq_valid low at n+1; next offer earliest n+2.
- Return at n -> cur_prio restored at n+1.
- Reset mid-offer or mid-nesting: all state to reset values next edge, no pending survives.

## Configuration
- CLIC_TIMESTAMP_EN: defined -> free-running TimeStampWidth counter (reset 0, wraps) captured into ts[i] whenever pending[i] goes 0->1; ts[i] readable at 0xb40+i, read-only, reset 0. Undefined -> no counter/registers, 0xb40+i read 0.

## Test plan
- Enable vec 3 prio 2, pulse ext_irq[3] -> irq_valid, irq_id=3 two cycles later; ready -> cur_prio=2, depth=1, pending[3]=0.
- Vecs 1 and 5 both prio 3 pending and enabled -> irq_id=1; after accept, vec 5 not offered (3 not > 3) until return.
- Running vec 3 prio 1, pend vec 6 prio 3 -> preempt, depth=2; two returns -> cur_prio 1 then 0, depth 0; extra return ignored.
- thresh=2, vec 0 prio 2 pending -> no irq_valid; thresh write 1 -> offered next cycle; in OFFER write thresh=3 -> irq_valid drops.
- Fill StackDepth=4 nesting with prio 0 running... levels 1,2,3 plus depth limit via reduced StackDepth=2 build -> third request held until return.
- CLIC_TIMESTAMP_EN: pend vec 2 at counter value 0x17 -> 0xb42 reads 0x17; re-pend after clear captures new value; counter wraps 0xff->0x00.
